// File: rtl/e203_dtcm_ram_ctrl_pkg.sv
// DTCM RAM controller shared definitions.
// Width defaults mirror the E203 DTCM RAM configuration.
package e203_dtcm_ram_ctrl_pkg;

  localparam int E203_DTCM_RAM_DW = 32;
  localparam int E203_DTCM_RAM_MW = E203_DTCM_RAM_DW / 8;
  localparam int E203_DTCM_RAM_AW = 14;

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_SLEEP  = 2'd1;
  localparam logic [1:0] ST_WAKE   = 2'd2;

endpackage

// File: rtl/e203_dtcm_rsp_fifo.sv
// Response FIFO for the DTCM controller.
// Outputs come straight from registers; empty entries read as zero.
module e203_dtcm_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 33,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  assign valid_o = (cnt_q != '0);
  assign dout_o  = valid_o ? mem_q[rptr_q] : '0;
  assign cnt_o   = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i)
      wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
    if (do_pop)
      rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
    unique case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i)
        mem_q[wptr_q] <= din_i;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/e203_dtcm_ram_ctrl.sv
// DTCM SRAM initiator: ICB command issue, ordered responses
// through a credit-guarded FIFO, and light-sleep control.
module e203_dtcm_ram_ctrl
  import e203_dtcm_ram_ctrl_pkg::*;
#(
  parameter int DW        = E203_DTCM_RAM_DW,
  parameter int MW        = E203_DTCM_RAM_MW,
  parameter int AW        = E203_DTCM_RAM_AW,
  parameter int ICB_AW    = 16,
  parameter int RSP_DEPTH = 3,
  parameter int IDLE_CYC  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic              icb_cmd_read,
  input  logic [ICB_AW-1:0] icb_cmd_addr,
  input  logic [DW-1:0]     icb_cmd_wdata,
  input  logic [MW-1:0]     icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [DW-1:0]     icb_rsp_rdata,
  output logic              icb_rsp_err,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [MW-1:0]     ram_wem,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  output logic              ram_ls,
  output logic              ram_ds,
  output logic              ram_sd
);

  localparam int CNTW = $clog2(RSP_DEPTH + 1);
  localparam int IW   = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam logic [IW-1:0] IDLE_LAST =
    IW'((IDLE_CYC > 0) ? IDLE_CYC - 1 : 0);
  localparam bit SLEEP_EN = (IDLE_CYC != 0);

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            infl_q, infl_d;
  logic            rd_q, rd_d;
  logic            err_q, err_d;
  logic            oor, hs, idle_cond;
  logic            fifo_valid;
  logic [CNTW-1:0] fifo_cnt;
  logic [CNTW:0]   occ;
  logic [DW:0]     push_ent, head;
  logic            unused_addr_lsb;

  generate
    if (ICB_AW > AW + 2) begin : g_oor
      assign oor = |icb_cmd_addr[ICB_AW-1:AW+2];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  assign unused_addr_lsb = ^icb_cmd_addr[1:0];

  // Credit counts the inflight slot so a push can never overflow.
  assign occ = {1'b0, fifo_cnt} + {{CNTW{1'b0}}, infl_q};
  assign icb_cmd_ready = ~rst & (state_q == ST_ACTIVE)
                       & (occ < (CNTW+1)'(RSP_DEPTH));
  assign hs = icb_cmd_valid & icb_cmd_ready;

  assign ram_cs   = hs & ~oor;
  assign ram_we   = ~rst & ~icb_cmd_read;
  assign ram_wem  = (rst | icb_cmd_read) ? '0 : icb_cmd_wmask;
  assign ram_din  = rst ? '0 : icb_cmd_wdata;
  assign ram_addr = rst ? '0 : icb_cmd_addr[AW+1:2];
  assign ram_ls   = (state_q == ST_SLEEP);
  assign ram_ds   = 1'b0;
  assign ram_sd   = 1'b0;

  assign infl_d = hs;
  assign rd_d   = icb_cmd_read;
  assign err_d  = oor;

  assign push_ent = {err_q, (rd_q & ~err_q) ? ram_dout : '0};

  e203_dtcm_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (DW + 1)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (infl_q),
    .din_i   (push_ent),
    .pop_i   (icb_rsp_ready),
    .valid_o (fifo_valid),
    .dout_o  (head),
    .cnt_o   (fifo_cnt)
  );

  assign icb_rsp_valid = fifo_valid;
  assign {icb_rsp_err, icb_rsp_rdata} = head;

  assign idle_cond = ~icb_cmd_valid & ~infl_q & ~fifo_valid;

  always_comb begin
    state_d = state_q;
    idle_d  = '0;
    unique case (1'b1)
      (state_q == ST_ACTIVE): begin
        if (SLEEP_EN && idle_cond) begin
          if (idle_q == IDLE_LAST)
            state_d = ST_SLEEP;
          else
            idle_d = idle_q + 1'b1;
        end
      end
      (state_q == ST_SLEEP): begin
        if (icb_cmd_valid)
          state_d = ST_WAKE;
      end
      (state_q == ST_WAKE): state_d = ST_ACTIVE;
      default:              state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACTIVE;
      idle_q  <= '0;
      infl_q  <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      infl_q  <= infl_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_e203_dtcm_ram_ctrl.sv
// Scoreboard bench for e203_dtcm_ram_ctrl with a byte-addressed
// reference memory and a simple SRAM model.
module tb_e203_dtcm_ram_ctrl;

  localparam int DW = 32;
  localparam int MW = 4;
  localparam int AW = 12;
  localparam int ICB_AW = 16;
  localparam int RSP_DEPTH = 3;
  localparam int IDLE_CYC = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              icb_cmd_valid = 1'b0;
  logic              icb_cmd_ready;
  logic              icb_cmd_read = 1'b0;
  logic [ICB_AW-1:0] icb_cmd_addr = '0;
  logic [DW-1:0]     icb_cmd_wdata = '0;
  logic [MW-1:0]     icb_cmd_wmask = '0;
  logic              icb_rsp_valid;
  logic              icb_rsp_ready = 1'b1;
  logic [DW-1:0]     icb_rsp_rdata;
  logic              icb_rsp_err;
  logic              ram_cs, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [MW-1:0]     ram_wem;
  logic [DW-1:0]     ram_din;
  logic [DW-1:0]     ram_dout = '0;
  logic              ram_ls, ram_ds, ram_sd;

  always #5 clk = ~clk;

  e203_dtcm_ram_ctrl #(
    .DW(DW), .MW(MW), .AW(AW), .ICB_AW(ICB_AW),
    .RSP_DEPTH(RSP_DEPTH), .IDLE_CYC(IDLE_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(icb_cmd_valid),
    .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read(icb_cmd_read),
    .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata),
    .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid),
    .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err),
    .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_pop = -100;
  bit          chk_lat = 1'b0;
  bit          rnd_rdy = 1'b0;
  logic [31:0] ram_mem [1<<AW];
  logic [7:0]  ref_b [1<<(AW+2)];

  function automatic logic [31:0] init_word(int i);
    return 32'h9E3779B9 * (i + 1);
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h",
               name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: one-cycle read latency, byte-masked writes
  initial begin
    for (int i = 0; i < (1<<AW); i++)
      ram_mem[i] = init_word(i);
    ram_mem[4] = '0;
    forever begin
      @(posedge clk);
      if (ram_cs) begin
        if (ram_we) begin
          for (int b = 0; b < MW; b++)
            if (ram_wem[b])
              ram_mem[ram_addr][8*b +: 8] = ram_din[8*b +: 8];
        end else begin
          ram_dout <= ram_mem[ram_addr];
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy)
      icb_rsp_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!rst && icb_rsp_valid && icb_rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rdata 0x%0h err %0d, required none",
                 icb_rsp_rdata, icb_rsp_err);
      end else begin
        me = q.pop_front();
        chk("rsp_rdata", icb_rsp_rdata, me.rdata);
        chk("rsp_err", icb_rsp_err, me.err);
        if (chk_lat)
          chk("rsp_latency", cyc - me.acc, 2);
      end
      last_pop = cyc;
    end
  end

  // Reference: byte-addressed memory; out-of-range gives err
  function automatic void record(bit rd, logic [15:0] a,
                                 logic [31:0] wd, logic [3:0] wm);
    exp_t e;
    int base;
    base = int'({a[13:2], 2'b00});
    e.acc = cyc;
    e.err = 1'b0;
    e.rdata = '0;
    if (a[15:14] != 2'b00) begin
      e.err = 1'b1;
    end else if (rd) begin
      for (int b = 0; b < 4; b++)
        e.rdata[8*b +: 8] = ref_b[base + b];
    end else begin
      for (int b = 0; b < 4; b++)
        if (wm[b]) ref_b[base + b] = wd[8*b +: 8];
    end
    q.push_back(e);
  endfunction

  task automatic issue(input bit rd, input logic [15:0] a,
                       input logic [31:0] wd,
                       input logic [3:0] wm,
                       output int acc);
    bit oor_e;
    oor_e = (a[15:14] != 2'b00);
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
    acc = -1;
    for (int w = 0; w < 40 && acc < 0; w++) begin
      @(negedge clk);
      if (icb_cmd_ready) begin
        acc = cyc;
        chk("ram_cs", ram_cs, !oor_e);
        if (!oor_e) begin
          chk("ram_addr", ram_addr, a[13:2]);
          chk("ram_we", ram_we, !rd);
          chk("ram_wem", ram_wem, rd ? 4'b0 : wm);
          if (!rd) chk("ram_din", ram_din, wd);
        end
        record(rd, a, wd, wm);
      end
    end
    @(posedge clk);
    #1;
    if (acc < 0) begin
      chk("accept_timeout", 0, 1);
      icb_cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    rnd_rdy = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_rsp_ready = 1'b1;
    while ((q.size() != 0 || icb_rsp_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", n < 200, 1);
  endtask

  task automatic wait_ls(input string name);
    int n;
    n = 0;
    while (!ram_ls && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, cyc - last_pop, IDLE_CYC + 1);
  endtask

  int          a0, a1, a2, acc;
  int          seen;
  logic [15:0] ra;

  initial begin
    for (int i = 0; i < (1<<AW); i++)
      for (int b = 0; b < 4; b++)
        ref_b[4*i + b] = init_word(i) >> (8*b);
    for (int b = 0; b < 4; b++)
      ref_b[16 + b] = 8'h00;

    // reset state with a command presented
    icb_cmd_valid = 1'b1;
    icb_cmd_wmask = 4'hF;
    #12;
    chk("rst_cmd_ready", icb_cmd_ready, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_wem", ram_wem, 0);
    chk("rst_rsp_valid", icb_rsp_valid, 0);
    chk("rst_ls_ds_sd", {ram_ls, ram_ds, ram_sd}, 0);
    icb_cmd_valid = 1'b0;
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // back-to-back reads
    chk_lat = 1'b1;
    issue(1, 16'h0000, 0, 0, a0);
    issue(1, 16'h0004, 0, 0, a1);
    issue(1, 16'h0008, 0, 0, a2);
    chk("b2b_acc1", a1 - a0, 1);
    chk("b2b_acc2", a2 - a1, 1);
    drain();

    // write then read over a zeroed word
    issue(0, 16'h0010, 32'hDEADBEEF, 4'b0101, acc);
    issue(1, 16'h0010, 0, 0, acc);
    drain();

    // out of range
    issue(1, 16'h8000, 0, 0, acc);
    drain();

    // sleep entry, wake, access
    wait_ls("sleep_entry_cycles");
    chk("sleep_ls", ram_ls, 1);
    @(posedge clk);
    #1;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = 16'h0020;
    @(negedge clk);
    chk("sleep_ready", icb_cmd_ready, 0);
    chk("sleep_ls_hold", ram_ls, 1);
    @(negedge clk);
    chk("wake_ready", icb_cmd_ready, 0);
    chk("wake_ls", ram_ls, 0);
    @(negedge clk);
    chk("wake_accept", icb_cmd_ready, 1);
    chk("wake_cs", ram_cs, 1);
    if (icb_cmd_ready) record(1, 16'h0020, 0, 0);
    @(posedge clk);
    #1;
    drain();
    wait_ls("sleep_reentry_cycles");

    // response backpressure
    chk_lat = 1'b0;
    @(posedge clk);
    #1;
    icb_rsp_ready = 1'b0;
    issue(1, 16'h0100, 0, 0, acc);
    issue(1, 16'h0104, 0, 0, acc);
    issue(1, 16'h0108, 0, 0, acc);
    icb_cmd_addr = 16'h010C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", icb_cmd_ready, 0);
    end
    chk("bp_rsp_valid", icb_rsp_valid, 1);
    @(posedge clk);
    #1;
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_no_comb", icb_cmd_ready, 0);
    @(posedge clk);
    #1;
    icb_rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_pop", icb_cmd_ready, 1);
    if (icb_cmd_ready) record(1, 16'h010C, 0, 0);
    @(posedge clk);
    #1;
    drain();

    // async reset with two queued and one inflight
    icb_rsp_ready = 1'b0;
    issue(1, 16'h0200, 0, 0, acc);
    issue(1, 16'h0204, 0, 0, acc);
    issue(1, 16'h0208, 0, 0, acc);
    icb_cmd_valid = 1'b0;
    #1;
    chk("pre_rst_rsp_valid", icb_rsp_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", icb_rsp_valid, 0);
    chk("mid_rst_cmd_ready", icb_cmd_ready, 0);
    q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    icb_rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (icb_rsp_valid) seen++;
    end
    chk("no_stale_rsp", seen, 0);
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    issue(1, 16'h0300, 0, 0, acc);
    drain();

    // randomized traffic with random response backpressure
    chk_lat = 1'b0;
    rnd_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = ($urandom_range(0, 15) == 0) ? 8 : $urandom_range(0, 2);
      icb_cmd_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      ra = 16'($urandom);
      if ($urandom_range(0, 7) != 0) ra[15:14] = 2'b00;
      issue(1'($urandom_range(0, 1)), ra, $urandom,
            4'($urandom), acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/e203_dtcm_ram_ctrl.md
Name: e203_dtcm_ram_ctrl

Overview:
- Initiator side of the DTCM SRAM port. Accepts ICB-style commands from the LSU/biu arbiter and drives the cs/we/addr/wem/din pins of the DTCM RAM wrapper.
- Captures dout one cycle after a read and returns ordered responses through a small response FIFO, so response backpressure never stalls the SRAM pipe.
- Owns light-sleep (ls) control: requests sleep after a programmable idle period and handles wake-up before the next access.

Parameters:
- DW, 32, data width (matches E203_DTCM_RAM_DW)
- MW, 4, byte-mask width, DW/8
- AW, 14, SRAM word-address width
- ICB_AW, 16, byte-address width of the command port; must be >= AW+2
- RSP_DEPTH, 3, response FIFO entries; legal range 2..4; 3 gives full throughput
- IDLE_CYC, 16, idle cycles before ls asserts; 0 disables sleep

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted when valid&ready
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_addr  in  ICB_AW  byte address
- icb_cmd_wdata  in  DW  write data
- icb_cmd_wmask  in  MW  byte enables
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response accepted
- icb_rsp_rdata  out  DW  read data; 0 for writes and errors
- icb_rsp_err  out  1  address out of range
- ram_cs, ram_we  out  1  SRAM chip select and write enable
- ram_addr  out  AW  word address, icb_cmd_addr[AW+1:2]
- ram_wem  out  MW  byte write mask
- ram_din  out  DW  write data
- ram_dout  in  DW  read data, valid the cycle after cs&~we
- ram_ls, ram_ds, ram_sd  out  1  light sleep; ds and sd tied 0

Behaviour:
- Reset values: all state clears to ACTIVE, FIFO empty, inflight=0, idle counter=0. While rst=1 all outputs are 0, including icb_cmd_ready.
- Issue:
  - ram_cs = icb_cmd_valid & icb_cmd_ready & ~oor, combinational in the handshake cycle.
  - ram_we = ~icb_cmd_read. ram_wem = icb_cmd_wmask when writing, else 0. ram_din = icb_cmd_wdata.
- Out of range (oor): any of icb_cmd_addr[ICB_AW-1:AW+2] nonzero. No RAM access occurs; the command still consumes a slot and produces err=1, rdata=0.
- Addresses are word-aligned. Bits [1:0] are ignored.
- Inflight stage: a 1-bit register with flags read/err set on handshake. In the next cycle the entry {rdata = read&~err ? ram_dout : 0, err} is pushed to the FIFO unconditionally. Fixed 2-cycle cmd-to-rsp_valid latency when the FIFO is empty.
- Credit:
  - icb_cmd_ready = (state==ACTIVE) & (fifo_cnt + inflight < RSP_DEPTH).
  - icb_cmd_ready must not depend combinationally on icb_rsp_ready. This guarantees a push never overflows.
- FIFO:
  - icb_rsp_valid = ~empty, registered. Data comes from the head entry.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo RSP_DEPTH. Responses are returned strictly in order.
- Sleep FSM, states ACTIVE, SLEEP, WAKE:
  - ACTIVE: the idle counter increments when ~icb_cmd_valid & ~inflight & fifo empty, and clears otherwise. When the count reaches IDLE_CYC-1 and the condition still holds → SLEEP, and ram_ls=1 from the next cycle.
  - SLEEP: ram_ls=1, cmd_ready=0. icb_cmd_valid → WAKE.
  - WAKE: ram_ls=0, cmd_ready=0 for exactly one cycle → ACTIVE. The command is accepted on the first ACTIVE cycle.
  - IDLE_CYC=0: the FSM stays in ACTIVE permanently.
- Reset mid-operation discards inflight and FIFO contents. No response is produced for them.

Decomposition:
- Shared package/defines: state encodings (ACTIVE=2'd0, SLEEP=2'd1, WAKE=2'd2) and DTCM width macros (E203_DTCM_RAM_DW/MW/AW) reused for DW/MW/AW defaults.
- One sub-module: e203_dtcm_rsp_fifo, a parameterised DEPTH × (DW+1) synchronous FIFO with count output, registered outputs, and async active-high reset.

Test Plan:
- Back-to-back reads, rsp_ready=1, ram model returns addr-derived data: reads to 0x0000, 0x0004, 0x0008 on consecutive cycles → cmd_ready stays 1, rsp_valid on cycles 2, 3, 4 with rdata matching each address in order, cs asserted 3 consecutive cycles.
- Write then read: write 0x0010 data 0xDEADBEEF wmask 4'b0101, then read 0x0010 → ram_wem=4'b0101 and ram_addr=4 on the write, write rsp rdata=0 err=0, read returns 0x00AD00EF over a zeroed model.
- Backpressure with rsp_ready=0: issue reads until stall → exactly 3 accepted, cmd_ready=0. Then raise rsp_ready for one cycle → one response popped and cmd_ready=1 the next cycle; no loss or reorder.
- Out of range, ICB_AW=16, AW=12: read 0x8000 → ram_cs stays 0, response after 2 cycles with err=1, rdata=0.
- Sleep with IDLE_CYC=4: 4 idle cycles → ram_ls=1. Then a read arrives → one WAKE cycle with ls=0 and cmd_ready=0, accepted on the following cycle, response correct.
- Async reset with 2 responses queued and 1 inflight: rst pulses mid-cycle → rsp_valid=0 immediately, no stale response afterwards, a subsequent read completes normally.
